// File: rtl/sink_nch.sv
// sink_nch: N-channel two-phase (toggle) handshake sink.
// Each channel captures a pending token (req != ack), counts it, optionally
// checks it against an incrementing sequence, then toggles ack after a
// programmable delay that per-channel stall can stretch.
module sink_nch #(
  parameter int          ID        = 0,
  parameter int unsigned N         = 4,
  parameter int unsigned SIZE      = 8,
  parameter int unsigned ACK_DELAY = 0,
  parameter int unsigned CW        = 16,
  parameter int unsigned CHECK     = 0,
  parameter int unsigned VERBOSE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*SIZE-1:0] data,
  input  logic [N-1:0]      stall,
  output logic [N-1:0]      ack,
  output logic [N*CW-1:0]   count,
  output logic [N*SIZE-1:0] last,
  output logic [N-1:0]      err
);

  localparam int unsigned DW = 8;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Reject parameter values outside their legal ranges at elaboration.
  if (N < 1 || SIZE < 1 || CW < 1 || ACK_DELAY > 255 ||
      CHECK > 1 || VERBOSE > 1 || ID < 0) begin : g_bad_param
    $error("sink_nch: illegal parameter value");
  end

  logic [0:0]      state_q [N];
  logic [0:0]      state_d [N];
  logic [DW-1:0]   dly_q   [N];
  logic [DW-1:0]   dly_d   [N];
  logic [SIZE-1:0] exp_q   [N];
  logic [SIZE-1:0] exp_d   [N];

  logic [N-1:0]      ack_d;
  logic [N-1:0]      err_d;
  logic [N*CW-1:0]   count_d;
  logic [N*SIZE-1:0] last_d;

  // State and output registers; reset drops any token in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= IDLE;
        dly_q[i]   <= '0;
        exp_q[i]   <= '0;
      end
      ack   <= '0;
      err   <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        dly_q[i]   <= dly_d[i];
        exp_q[i]   <= exp_d[i];
      end
      ack   <= ack_d;
      err   <= err_d;
      count <= count_d;
      last  <= last_d;
    end
  end

  // Per-channel next-state: capture in IDLE, delay/stall then ack in HOLD.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      dly_d[i]   = dly_q[i];
      exp_d[i]   = exp_q[i];
    end
    ack_d   = ack;
    err_d   = err;
    count_d = count;
    last_d  = last;

    for (int i = 0; i < N; i++) begin
      case (state_q[i])
        IDLE: begin
          if (req[i] != ack[i]) begin
            last_d[i*SIZE +: SIZE] = data[i*SIZE +: SIZE];
            count_d[i*CW +: CW]    = count[i*CW +: CW] + CW'(1);
            dly_d[i]               = DW'(ACK_DELAY);
            if (CHECK != 0) begin
              if (data[i*SIZE +: SIZE] != exp_q[i]) err_d[i] = 1'b1;
              // Resynchronise on the received value so one bad flit flags once.
              exp_d[i] = data[i*SIZE +: SIZE] + SIZE'(1);
            end
            state_d[i] = HOLD;
          end
        end
        HOLD: begin
          if (!stall[i]) begin
            if (dly_q[i] == '0) begin
              ack_d[i]   = ~ack[i];
              state_d[i] = IDLE;
            end else begin
              dly_d[i] = dly_q[i] - DW'(1);
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

endmodule
